// File: rtl/snake_pkg.sv
// Shared snake types and helpers: direction and game-state encodings plus grid indexing.
// Used by the body engine, the apple generator and the renderer.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10,
    ST_WON  = 2'b11
  } state_t;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      default:   return DIR_LEFT;
    endcase
  endfunction

  // Column-major cell index into the occupancy vector.
  function automatic int unsigned xy_to_idx(input int unsigned x, input int unsigned y,
                                            input int unsigned grid_h);
    return x * grid_h + y;
  endfunction

endpackage

// File: rtl/snake_ring_buffer.sv
// Circular store of body cells, tail (oldest) to head (newest).
// tail_next is the slot after the tail, i.e. the tail cell once a pop lands.
module snake_ring_buffer #(
  parameter int MAX_LEN = 225,
  parameter int EW      = 8,
  parameter logic [EW-1:0] INIT0 = '0,
  parameter logic [EW-1:0] INIT1 = '0,
  parameter logic [EW-1:0] INIT2 = '0
) (
  input  logic          Clk,
  input  logic          Reset_N,
  input  logic          init,
  input  logic          push_head,
  input  logic [EW-1:0] head_in,
  input  logic          pop_tail,
  output logic [EW-1:0] tail_next
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [EW-1:0] mem [MAX_LEN];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
  endfunction

  assign tail_next = mem[inc(tail_ptr)];

  always_ff @(posedge Clk) begin
    if (!Reset_N || init) begin
      mem[0]   <= INIT0;
      mem[1]   <= INIT1;
      mem[2]   <= INIT2;
      head_ptr <= PW'(2);
      tail_ptr <= '0;
    end else begin
      if (push_head) begin
        mem[inc(head_ptr)] <= head_in;
        head_ptr           <= inc(head_ptr);
      end
      if (pop_tail) tail_ptr <= inc(tail_ptr);
    end
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body engine: FSM, movement, growth, wall/self collision, win and grid occupancy.
// Start/Clear/Step/Dir_Valid are single-cycle pulses with no back-pressure; Step acts only in RUN.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int GRID_W  = 15,
  parameter int GRID_H  = 15,
  parameter int MAX_LEN = 225,
  parameter int GROW_BY = 1,
  parameter int WRAP    = 0,
  localparam int CW = $clog2(GRID_W),
  localparam int CH = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic                     Clk,
  input  logic                     Reset_N,
  input  logic                     Start,
  input  logic                     Clear,
  input  logic                     Step,
  input  logic                     Dir_Valid,
  input  logic [1:0]               In_Dirn,
  input  logic [CW-1:0]            Apple_X,
  input  logic [CH-1:0]            Apple_Y,
  output logic [CW-1:0]            Head_X,
  output logic [CH-1:0]            Head_Y,
  output logic [CW-1:0]            Tail_X,
  output logic [CH-1:0]            Tail_Y,
  output logic [LW-1:0]            Length,
  output logic [GRID_W*GRID_H-1:0] Occupancy,
  output logic                     Ate,
  output logic [1:0]               State
);

  localparam int NC  = GRID_W * GRID_H;
  localparam int IW  = $clog2(NC);
  localparam int EW  = CW + CH;
  localparam int GPW = LW + 3;
  localparam logic [CW-1:0] X0     = CW'(GRID_W / 2);
  localparam logic [CH-1:0] Y_HEAD = CH'(GRID_H / 2);
  localparam logic [CH-1:0] Y_MID  = CH'(GRID_H / 2 - 1);
  localparam logic [CH-1:0] Y_TAIL = CH'(GRID_H / 2 - 2);
  localparam int IDX_HEAD = (GRID_W / 2) * GRID_H + GRID_H / 2;

  state_t         state;
  dir_t           cur_dirn, pend_dirn, step_dirn;
  logic [CW-1:0]  head_x, tail_x, nx;
  logic [CH-1:0]  head_y, tail_y, ny;
  logic [LW-1:0]  length;
  logic [GPW-1:0] grow_pending;
  logic [NC-1:0]  occ, occ_next;
  logic           ate;
  logic [IW-1:0]  next_idx, tail_idx;
  logic           oob, eat, tail_moves, self_hit, collision, do_move, push_head, pop_tail;
  logic [EW-1:0]  tail_next;

  always_comb begin
    step_dirn = (pend_dirn == opposite(cur_dirn)) ? cur_dirn : pend_dirn;
    nx  = head_x;
    ny  = head_y;
    oob = 1'b0;
    // Out-of-range moves still produce a wrapped cell so the index below stays in range.
    case (step_dirn)
      DIR_UP:    if (head_y == '0) begin oob = (WRAP == 0); ny = CH'(GRID_H - 1); end
                 else ny = head_y - 1'b1;
      DIR_DOWN:  if (head_y == CH'(GRID_H - 1)) begin oob = (WRAP == 0); ny = '0; end
                 else ny = head_y + 1'b1;
      DIR_LEFT:  if (head_x == '0) begin oob = (WRAP == 0); nx = CW'(GRID_W - 1); end
                 else nx = head_x - 1'b1;
      DIR_RIGHT: if (head_x == CW'(GRID_W - 1)) begin oob = (WRAP == 0); nx = '0; end
                 else nx = head_x + 1'b1;
    endcase
    next_idx   = IW'(xy_to_idx(32'(nx), 32'(ny), GRID_H));
    tail_idx   = IW'(xy_to_idx(32'(tail_x), 32'(tail_y), GRID_H));
    eat        = (nx == Apple_X) && (ny == Apple_Y);
    tail_moves = (grow_pending == '0) && !eat;
    self_hit   = occ[next_idx] && !(tail_moves && nx == tail_x && ny == tail_y);
    collision  = oob || self_hit;
    do_move    = (state == ST_RUN) && Step && !Clear;
    push_head  = do_move && !collision;
    pop_tail   = push_head && tail_moves;
    occ_next   = occ;
    if (tail_moves) occ_next[tail_idx] = 1'b0;
    occ_next[next_idx] = 1'b1;
  end

  snake_ring_buffer #(
    .MAX_LEN (MAX_LEN),
    .EW      (EW),
    .INIT0   ({X0, Y_TAIL}),
    .INIT1   ({X0, Y_MID}),
    .INIT2   ({X0, Y_HEAD})
  ) u_ring (
    .Clk       (Clk),
    .Reset_N   (Reset_N),
    .init      (Clear),
    .push_head (push_head),
    .head_in   ({nx, ny}),
    .pop_tail  (pop_tail),
    .tail_next (tail_next)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_N || Clear) begin
      state                  <= ST_IDLE;
      cur_dirn               <= DIR_DOWN;
      pend_dirn              <= DIR_DOWN;
      head_x                 <= X0;
      head_y                 <= Y_HEAD;
      tail_x                 <= X0;
      tail_y                 <= Y_TAIL;
      length                 <= LW'(3);
      grow_pending           <= '0;
      ate                    <= 1'b0;
      occ                    <= '0;
      occ[IW'(IDX_HEAD)]     <= 1'b1;
      occ[IW'(IDX_HEAD - 1)] <= 1'b1;
      occ[IW'(IDX_HEAD - 2)] <= 1'b1;
    end else begin
      ate <= 1'b0;
      if (Dir_Valid) pend_dirn <= dir_t'(In_Dirn);
      if (state == ST_IDLE && Start) state <= ST_RUN;
      if (do_move) begin
        cur_dirn <= step_dirn;
        if (collision) begin
          state <= ST_DEAD;
        end else begin
          head_x <= nx;
          head_y <= ny;
          ate    <= eat;
          occ    <= occ_next;
          if (eat) grow_pending <= grow_pending + GPW'(GROW_BY - 1);
          else if (grow_pending != '0) grow_pending <= grow_pending - 1'b1;
          if (tail_moves) begin
            {tail_x, tail_y} <= tail_next;
          end else begin
            length <= length + 1'b1;
            if (length == LW'(MAX_LEN - 1)) begin
              state        <= ST_WON;
              grow_pending <= '0;
            end
          end
        end
      end
    end
  end

  assign Head_X    = head_x;
  assign Head_Y    = head_y;
  assign Tail_X    = tail_x;
  assign Tail_Y    = tail_y;
  assign Length    = length;
  assign Occupancy = occ;
  assign Ate       = ate;
  assign State     = state;

endmodule
